// File: rtl/enc_quad_velocity.sv
// enc_quad_velocity: filtered x4 quadrature decoder with a position counter,
// a windowed velocity measurement and a sticky illegal-transition flag.
module enc_quad_velocity #(
  parameter int FILT   = 3,
  parameter int WINDOW = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cla,
  input  logic               clb,
  input  logic               err_clr,
  output logic signed [15:0] pos,
  output logic signed [15:0] vel,
  output logic               vel_valid,
  output logic               dir,
  output logic               err
);
  localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WW-1:0] WLAST = WW'(WINDOW - 1);
  localparam logic [3:0] FLAST = 4'(FILT - 1);
  logic [1:0] s1_q, s2_q, f_q, f_d, cur_q, prev_q, d;
  logic [1:0][3:0] cnt_q, cnt_d;
  logic v_q, fwd, rev, ill, wend, vv_q, dir_q, err_q;
  logic [WW-1:0] win_q;
  logic signed [15:0] pos_q, acc_q, vel_q, step, acc_sat;
  logic signed [16:0] sum;
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = (s2_q[i] != f_q[i] && cnt_q[i] != FLAST) ? cnt_q[i] + 4'd1 : 4'd0;
      f_d[i] = (s2_q[i] != f_q[i] && cnt_q[i] == FLAST) ? s2_q[i] : f_q[i];
    end
    // {A, A^B} turns the Gray sequence 00,01,11,10 into a binary phase 0..3
    d = {cur_q[1], ^cur_q} - {prev_q[1], ^prev_q};
    fwd = d == 2'd1;
    rev = d == 2'd3;
    ill = d == 2'd2;
    step = fwd ? 16'sd1 : rev ? -16'sd1 : 16'sd0;
    sum = {acc_q[15], acc_q} + {step[15], step};
    acc_sat = (sum[16] != sum[15]) ? (sum[16] ? 16'sh8000 : 16'sh7fff) : sum[15:0];
    wend = win_q == WLAST;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      f_q    <= '0;
      cnt_q  <= '0;
      v_q    <= 1'b0;
      cur_q  <= '0;
      prev_q <= '0;
      pos_q  <= '0;
      dir_q  <= 1'b0;
      err_q  <= 1'b0;
      win_q  <= '0;
      acc_q  <= '0;
      vel_q  <= '0;
      vv_q   <= 1'b0;
    end else begin
      s1_q   <= {cla, clb};
      s2_q   <= s1_q;
      f_q    <= f_d;
      cnt_q  <= cnt_d;
      v_q    <= 1'b1;
      cur_q  <= f_q;
      // first sample after reset seeds both history stages so it cannot step
      prev_q <= v_q ? cur_q : f_q;
      pos_q  <= pos_q + step;
      dir_q  <= (fwd | rev) ? fwd : dir_q;
      err_q  <= err_clr ? 1'b0 : (err_q | ill);
      win_q  <= wend ? '0 : win_q + WW'(1);
      acc_q  <= wend ? 16'sd0 : acc_sat;
      vel_q  <= wend ? acc_sat : vel_q;
      vv_q   <= wend;
    end
  end
  assign pos       = pos_q;
  assign vel       = vel_q;
  assign vel_valid = vv_q;
  assign dir       = dir_q;
  assign err       = err_q;
endmodule

// File: tb/tb_enc_quad_velocity.sv
// tb_enc_quad_velocity: cycle-level reference model of commanded encoder motion
// for a small-window instance, plus a wrap/saturation run on a fast-filter instance.
module tb_enc_quad_velocity;
  localparam int F1 = 3;
  localparam int W1 = 100;
  logic clk = 1'b0, rst_n = 1'b0, cla = 1'b0, clb = 1'b0, err_clr = 1'b0;
  logic cla2 = 1'b0, clb2 = 1'b0;
  logic signed [15:0] pos, vel, pos2, vel2;
  logic vel_valid, dir, err, vv2, dir2, err2;
  int total = 0, bad = 0, e = 0, ph = 0, ph2 = 0;
  int sched [int];
  bit esched [int];
  logic signed [15:0] ref_pos = 0, ref_vel = 0;
  int ref_acc = 0;
  bit ref_dir = 0, ref_err = 0, ref_vv = 0;
  logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  enc_quad_velocity #(.FILT(F1), .WINDOW(W1)) u (
    .clk(clk), .rst_n(rst_n), .cla(cla), .clb(clb), .err_clr(err_clr),
    .pos(pos), .vel(vel), .vel_valid(vel_valid), .dir(dir), .err(err)
  );
  enc_quad_velocity #(.FILT(1), .WINDOW(40000)) u2 (
    .clk(clk), .rst_n(rst_n), .cla(cla2), .clb(clb2), .err_clr(1'b0),
    .pos(pos2), .vel(vel2), .vel_valid(vv2), .dir(dir2), .err(err2)
  );
  always #5 clk = ~clk;
  task automatic check(string tag, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got=%0d exp=%0d", tag, e, got, exp);
    end
  endtask
  task automatic tick();
    int s;
    @(posedge clk);
    e++;
    s = sched.exists(e) ? sched[e] : 0;
    sched.delete(e);
    ref_pos = ref_pos + 16'(s);
    if (s != 0) ref_dir = s > 0;
    ref_acc = ref_acc + s;
    ref_acc = ref_acc > 32767 ? 32767 : ref_acc < -32768 ? -32768 : ref_acc;
    if (err_clr) ref_err = 0;
    else if (esched.exists(e)) ref_err = 1;
    esched.delete(e);
    ref_vv = (e % W1) == 0;
    if (ref_vv) begin
      ref_vel = 16'(ref_acc);
      ref_acc = 0;
    end
    #1;
    check("pos", int'(pos), int'(ref_pos));
    check("dir", int'(dir), int'(ref_dir));
    check("err", int'(err), int'(ref_err));
    check("vel_valid", int'(vel_valid), int'(ref_vv));
    check("vel", int'(vel), int'(ref_vel));
  endtask
  // k: +1 forward, -1 reverse, 2 illegal (both channels flip)
  task automatic move(int k, int hold);
    int t;
    t = e + F1 + 4;
    if (k == 2) esched[t] = 1;
    else sched[t] = k;
    ph = (ph + (k == 2 ? 2 : k == 1 ? 1 : 3)) % 4;
    {cla, clb} = seq[ph];
    repeat (hold) tick();
  endtask
  initial begin
    int p0;
    #1;
    check("rst_pos", int'(pos), 0);
    check("rst_vel", int'(vel), 0);
    check("rst_vv", int'(vel_valid), 0);
    check("rst_dir", int'(dir), 0);
    check("rst_err", int'(err), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) move(1, 8);
    repeat (12) tick();
    check("fwd40_pos", int'(pos), 40);
    check("fwd40_dir", int'(dir), 1);
    check("fwd40_err", int'(err), 0);
    repeat (60) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4) move(1, $urandom_range(F1, 10));
      else if (r < 8) move(-1, $urandom_range(F1, 10));
      else if (r == 8) move(2, $urandom_range(F1, 10));
      else begin
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();
      end
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    if (ph % 2 == 0) move(1, 10);
    repeat (10) tick();
    p0 = int'(pos);
    cla = ~cla;
    repeat (2) tick();
    cla = ~cla;
    repeat (12) tick();
    check("glitch2_pos", int'(pos), p0);
    move(1, 3);
    move(-1, 12);
    check("pulse3_pos", int'(pos), p0);
    check("pulse3_dir", int'(dir), 0);
    move(2, 12);
    check("ill_err", int'(err), 1);
    check("ill_pos", int'(pos), p0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tick();
    check("errclr", int'(err), 0);
    while (ph != 0) move(1, 6);
    repeat (10) tick();
    while (e % W1 != 0) tick();
    repeat (12) move(1, 3);
    while (e % W1 != 50) tick();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_pos", int'(pos), 0);
    check("mid_rst_vel", int'(vel), 0);
    check("mid_rst_vv", int'(vel_valid), 0);
    check("mid_rst_dir", int'(dir), 0);
    check("mid_rst_err", int'(err), 0);
    sched.delete();
    esched.delete();
    ref_pos = 0;
    ref_vel = 0;
    ref_acc = 0;
    ref_dir = 0;
    ref_err = 0;
    @(negedge clk);
    rst_n = 1'b1;
    e = 0;
    repeat (99) tick();
    check("first_win_early", int'(vel_valid), 0);
    tick();
    check("first_win", int'(vel_valid), 1);
    repeat (20) move(-1, 8);
    repeat (12) tick();
    check("rev20_pos", int'(pos), -20);
    check("rev20_dir", int'(dir), 0);
    repeat (32765) begin
      ph2 = (ph2 + 1) % 4;
      {cla2, clb2} = seq[ph2];
      tick();
    end
    repeat (8) tick();
    check("u2_pos_32765", int'(pos2), 32765);
    repeat (4) begin
      ph2 = (ph2 + 1) % 4;
      {cla2, clb2} = seq[ph2];
      tick();
    end
    repeat (8) tick();
    check("u2_pos_wrap", int'(pos2), -32767);
    check("u2_dir", int'(dir2), 1);
    check("u2_err", int'(err2), 0);
    for (int i = 0; i < 10000 && !vv2; i++) tick();
    check("u2_vv_seen", int'(vv2), 1);
    check("u2_vel_sat", int'(vel2), 32767);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
